// File: rtl/tlb_op_ctrl_pkg.sv
// Shared encodings for the TLB instruction controller: op types, FSM states
// and the CP0 Index value produced by a TLBP search.
package tlb_op_ctrl_pkg;

    // TLB instruction type as presented by the WB stage
    localparam logic [1:0] OpNone  = 2'b00;
    localparam logic [1:0] OpTlbp  = 2'b01;
    localparam logic [1:0] OpTlbr  = 2'b10;
    localparam logic [1:0] OpTlbwi = 2'b11;

    // Controller states (binary encoded)
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StReq     = 3'd1;
    localparam logic [2:0] StCommit  = 3'd2;
    localparam logic [2:0] StWrite   = 3'd3;
    localparam logic [2:0] StRefetch = 3'd4;

    // CP0 Index after TLBP: bit 31 is the probe-failure flag, the index field
    // is cleared on a miss. idx must arrive zero-extended.
    function automatic logic [31:0] tlbp_index_val(input logic hit, input logic [31:0] idx);
        return {~hit, hit ? idx[30:0] : 31'd0};
    endfunction

endpackage

// File: rtl/tlb_op_ctrl.sv
// Sequences committed TLBP / TLBR / TLBWI instructions from WB: issues the
// search/read to the TLB, writes the result into CP0, and for instructions
// that change the address mapping forces a flush and refetch at pc+4.
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int unsigned TLBNUM  = 16,
    parameter int unsigned ENTRY_W = 78,
    localparam int unsigned IW     = $clog2(TLBNUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    input  logic [1:0]         op_type,
    input  logic [31:0]        op_pc,
    output logic               op_ready,
    output logic               busy,
    output logic               tlb_req,
    output logic               tlb_req_is_read,
    input  logic               tlb_rsp_valid,
    input  logic               tlb_rsp_hit,
    input  logic [IW-1:0]      tlb_rsp_index,
    input  logic [ENTRY_W-1:0] tlb_rsp_entry,
    output logic               tlb_we,
    output logic               tlbp_wen,
    output logic [31:0]        tlbp_index,
    output logic               tlbr_wen,
    output logic [ENTRY_W-1:0] tlbr_entry,
    output logic               refetch,
    output logic [31:0]        refetch_pc
);

    logic [2:0]         state_q, state_d;
    logic [1:0]         type_q;
    logic [31:0]        refetch_pc_q;
    logic [31:0]        tlbp_index_q;
    logic [ENTRY_W-1:0] tlbr_entry_q;
    logic               accept;
    logic               rsp_take;

    assign accept   = op_valid && (state_q == StIdle) && (op_type != OpNone);
    // Responses are only meaningful while a request is outstanding
    assign rsp_take = (state_q == StReq) && tlb_rsp_valid;

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (op_type == OpTlbwi) ? StWrite : StReq;
                end
            end
            StReq: begin
                if (tlb_rsp_valid) begin
                    state_d = StCommit;
                end
            end
            StCommit:  state_d = (type_q == OpTlbr) ? StRefetch : StIdle;
            StWrite:   state_d = StRefetch;
            StRefetch: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // State and captured operands; reset wins over everything, dropping any response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            type_q       <= OpNone;
            refetch_pc_q <= 32'd0;
            tlbp_index_q <= 32'd0;
            tlbr_entry_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                type_q       <= op_type;
                refetch_pc_q <= op_pc + 32'd4;
            end
            if (rsp_take) begin
                if (type_q == OpTlbp) begin
                    tlbp_index_q <= tlbp_index_val(tlb_rsp_hit, 32'(tlb_rsp_index));
                end
                if (type_q == OpTlbr) begin
                    tlbr_entry_q <= tlb_rsp_entry;
                end
            end
        end
    end

    // Outputs decoded from the current state; each strobe owns a distinct state
    always_comb begin
        op_ready        = (state_q == StIdle);
        busy            = (state_q != StIdle);
        tlb_req         = (state_q == StReq);
        tlb_req_is_read = (state_q == StReq) && (type_q == OpTlbr);
        tlbp_wen        = (state_q == StCommit) && (type_q == OpTlbp);
        tlbr_wen        = (state_q == StCommit) && (type_q == OpTlbr);
        tlb_we          = (state_q == StWrite);
        refetch         = (state_q == StRefetch);
        tlbp_index      = tlbp_index_q;
        tlbr_entry      = tlbr_entry_q;
        refetch_pc      = refetch_pc_q;
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: table of TLB ops with expected CP0/refetch results
// fed through a strobe scoreboard, plus hand sequences for reset and idle cases.
module tb_tlb_op_ctrl;
    import tlb_op_ctrl_pkg::*;

    localparam int unsigned TLBNUM  = 16;
    localparam int unsigned ENTRY_W = 78;
    localparam int unsigned IW      = 4;

    localparam int EvTlbp    = 1;
    localparam int EvTlbr    = 2;
    localparam int EvWe      = 3;
    localparam int EvRefetch = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               op_valid = 1'b0;
    logic [1:0]         op_type = 2'b00;
    logic [31:0]        op_pc = 32'd0;
    logic               op_ready, busy, tlb_req, tlb_req_is_read;
    logic               tlb_rsp_valid = 1'b0;
    logic               tlb_rsp_hit = 1'b0;
    logic [IW-1:0]      tlb_rsp_index = '0;
    logic [ENTRY_W-1:0] tlb_rsp_entry = '0;
    logic               tlb_we, tlbp_wen, tlbr_wen, refetch;
    logic [31:0]        tlbp_index, refetch_pc;
    logic [ENTRY_W-1:0] tlbr_entry;

    tlb_op_ctrl #(
        .TLBNUM (TLBNUM),
        .ENTRY_W(ENTRY_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .op_valid       (op_valid),
        .op_type        (op_type),
        .op_pc          (op_pc),
        .op_ready       (op_ready),
        .busy           (busy),
        .tlb_req        (tlb_req),
        .tlb_req_is_read(tlb_req_is_read),
        .tlb_rsp_valid  (tlb_rsp_valid),
        .tlb_rsp_hit    (tlb_rsp_hit),
        .tlb_rsp_index  (tlb_rsp_index),
        .tlb_rsp_entry  (tlb_rsp_entry),
        .tlb_we         (tlb_we),
        .tlbp_wen       (tlbp_wen),
        .tlbp_index     (tlbp_index),
        .tlbr_wen       (tlbr_wen),
        .tlbr_entry     (tlbr_entry),
        .refetch        (refetch),
        .refetch_pc     (refetch_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] pc;
        int          req_cycles;
        bit          hold;
        logic        hit;
        logic [3:0]  idx;
        logic [77:0] entry;
        logic [31:0] exp_index;
        logic [77:0] exp_entry;
        logic [31:0] exp_pc;
        int          exp_lat;
    } vec_t;

    typedef struct {
        int          kind;
        logic [77:0] data;
    } ev_t;

    vec_t vecs[7];
    ev_t  exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [77:0] act, input logic [77:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Match every strobe seen against the next expected event
    task automatic scoreboard_check();
        int   n;
        int   kind;
        ev_t  e;
        logic [77:0] act;
        n = int'(tlb_we) + int'(tlbp_wen) + int'(tlbr_wen) + int'(refetch);
        if (n == 0) return;
        check("strobe_count", 78'(n), 78'd1);
        kind = tlbp_wen ? EvTlbp : tlbr_wen ? EvTlbr : tlb_we ? EvWe : EvRefetch;
        act  = (kind == EvTlbp) ? 78'(tlbp_index) : (kind == EvTlbr) ? tlbr_entry :
               (kind == EvRefetch) ? 78'(refetch_pc) : 78'd0;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: got kind %0d data 0x%0h, expected none", kind, act);
            return;
        end
        e = exp_q.pop_front();
        check("strobe_kind", 78'(kind), 78'(e.kind));
        check("strobe_data", act, e.data);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst) scoreboard_check();
    endtask

    task automatic push(input int kind, input logic [77:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic run_op(input vec_t v);
        int cycles;
        op_valid = 1'b1;
        op_type  = v.op;
        op_pc    = v.pc;
        check("accept_ready", 78'(op_ready), 78'd1);
        case (v.op)
            OpTlbp: push(EvTlbp, 78'(v.exp_index));
            OpTlbr: begin
                push(EvTlbr, v.exp_entry);
                push(EvRefetch, 78'(v.exp_pc));
            end
            default: begin
                push(EvWe, 78'd0);
                push(EvRefetch, 78'(v.exp_pc));
            end
        endcase
        step();
        cycles = 1;
        if (!v.hold) op_valid = 1'b0;
        if (v.op != OpTlbwi) begin
            for (int i = 1; i <= v.req_cycles; i++) begin
                check("req_high", 78'(tlb_req), 78'd1);
                check("req_is_read", 78'(tlb_req_is_read), 78'(v.op == OpTlbr));
                check("ready_low", 78'(op_ready), 78'd0);
                if (i == v.req_cycles) begin
                    tlb_rsp_valid = 1'b1;
                    tlb_rsp_hit   = v.hit;
                    tlb_rsp_index = v.idx;
                    tlb_rsp_entry = v.entry;
                end
                step();
                cycles++;
                tlb_rsp_valid = 1'b0;
            end
            check("req_drop", 78'(tlb_req), 78'd0);
        end
        op_valid = 1'b0;
        while (!op_ready && cycles < 20) begin
            step();
            cycles++;
        end
        check("latency", 78'(cycles), 78'(v.exp_lat));
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] pc, input int rc,
                                input bit hold, input logic hit, input logic [3:0] idx,
                                input logic [77:0] entry, input logic [31:0] ei,
                                input logic [77:0] ee, input logic [31:0] ep, input int lat);
        vec_t v;
        v.op = op; v.pc = pc; v.req_cycles = rc; v.hold = hold; v.hit = hit; v.idx = idx;
        v.entry = entry; v.exp_index = ei; v.exp_entry = ee; v.exp_pc = ep; v.exp_lat = lat;
        return v;
    endfunction

    initial begin
        vecs[0] = mk(OpTlbp, 32'h0040_0000, 1, 0, 1'b1, 4'd5, 78'h0, 32'h0000_0005, 78'h0,
                     32'h0, 3);
        vecs[1] = mk(OpTlbp, 32'h0040_0010, 1, 0, 1'b0, 4'd9, 78'h0, 32'h8000_0000, 78'h0,
                     32'h0, 3);
        vecs[2] = mk(OpTlbr, 32'hBFC0_0100, 1, 0, 1'b0, 4'd0, 78'h1234, 32'h0, 78'h1234,
                     32'hBFC0_0104, 4);
        vecs[3] = mk(OpTlbwi, 32'hFFFF_FFFC, 0, 0, 1'b0, 4'd0, 78'h0, 32'h0, 78'h0,
                     32'h0000_0000, 3);
        vecs[4] = mk(OpTlbp, 32'h0000_2000, 4, 1, 1'b1, 4'd15, 78'h0, 32'h0000_000F, 78'h0,
                     32'h0, 6);
        vecs[5] = mk(OpTlbr, 32'h8000_0000, 2, 0, 1'b1, 4'd7, 78'h3_FEDC_BA98_7654_3210_ABC,
                     32'h0, 78'h3_FEDC_BA98_7654_3210_ABC, 32'h8000_0004, 5);
        vecs[6] = mk(OpTlbp, 32'h0000_3000, 1, 0, 1'b1, 4'd0, 78'h0, 32'h0000_0000, 78'h0,
                     32'h0, 3);

        // Reset state
        repeat (2) step();
        rst = 1'b0;
        #1;
        check("rst_ready", 78'(op_ready), 78'd1);
        check("rst_busy", 78'(busy), 78'd0);
        check("rst_req", 78'(tlb_req), 78'd0);
        check("rst_strobes", 78'({tlb_we, tlbp_wen, tlbr_wen, refetch}), 78'd0);
        check("rst_tlbp_index", 78'(tlbp_index), 78'd0);
        check("rst_tlbr_entry", tlbr_entry, 78'd0);
        check("rst_refetch_pc", 78'(refetch_pc), 78'd0);

        // op_type none is never accepted
        op_valid = 1'b1;
        op_type  = OpNone;
        step();
        check("none_ready", 78'(op_ready), 78'd1);
        check("none_busy", 78'(busy), 78'd0);
        op_valid = 1'b0;

        // Stray response while idle must not land in CP0
        tlb_rsp_valid = 1'b1;
        tlb_rsp_hit   = 1'b1;
        tlb_rsp_index = 4'd3;
        tlb_rsp_entry = 78'hABCD;
        step();
        tlb_rsp_valid = 1'b0;
        check("idle_rsp_index", 78'(tlbp_index), 78'd0);
        check("idle_rsp_entry", tlbr_entry, 78'd0);
        check("idle_rsp_ready", 78'(op_ready), 78'd1);

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset while a TLBP waits for its response; the late response is dropped
        rst = 1'b1;
        step();
        rst = 1'b0;
        op_valid = 1'b1;
        op_type  = OpTlbp;
        op_pc    = 32'h0000_4000;
        step();
        op_valid = 1'b0;
        check("mid_busy", 78'(busy), 78'd1);
        rst = 1'b1;
        tlb_rsp_valid = 1'b1;
        tlb_rsp_hit   = 1'b1;
        tlb_rsp_index = 4'd3;
        step();
        rst = 1'b0;
        check("rst_mid_ready", 78'(op_ready), 78'd1);
        check("rst_mid_busy", 78'(busy), 78'd0);
        check("rst_mid_index", 78'(tlbp_index), 78'd0);
        step();
        tlb_rsp_valid = 1'b0;
        check("late_rsp_ready", 78'(op_ready), 78'd1);
        check("late_rsp_index", 78'(tlbp_index), 78'd0);
        repeat (3) step();

        check("scoreboard_empty", 78'(exp_q.size()), 78'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
